fetch_buffer: RTL and testbench

- Multi-cycle instruction fetch stage, directly upstream of decode (the yID stage).
- Replaces the single-cycle PC-register/memory fetch.
- Owns the PC, issues one-outstanding requests to a variable-latency instruction memory, and buffers returned instructions in a small FIFO.
- Presents {ins, pc, pcp4} to decode with a valid/ready handshake; flushes on redirect (branch, jump, INT).

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_buffer_if.sv | 27 ++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_buffer.sv | 126 ++++++++++++
 tb/tb_fetch_buffer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - types and constants shared by the fetch stage
`timescale 1ns/1ps
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] pcp4;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [31:0] NOP_INS = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// rtl/fetch_buffer_if.sv - instruction memory and decode-side handshake bundle
`timescale 1ns/1ps
interface fetch_buffer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins;
    logic [31:0] pc_out;
    logic [31:0] pcp4_out;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output ins_valid, ins, pc_out, pcp4_out,
        input  ins_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  ins_valid, ins, pc_out, pcp4_out,
        output ins_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small FIFO of fetched {ins, pc, pcp4} entries with flush
`timescale 1ns/1ps
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          empty;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty && !flush;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
    assign do_push = push && !flush && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head  = empty ? '0 : mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - multi-cycle fetch stage: PC, one-outstanding imem requests, FIFO to decode
// Optional stall counter output enabled by FETCH_PERF_CNT_EN.
`timescale 1ns/1ps
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    localparam int         CW       = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           redirect,
    input  logic [31:0]    redirect_pc,
    fetch_buffer_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]    stall_cnt
`endif
);

    fetch_state_t  state;
    fetch_state_t  state_d;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_d;
    logic [31:0]   req_addr;
    logic [31:0]   req_addr_d;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;
    logic          space_after;
    logic          push;
    logic          pop;
    fetch_entry_t  push_data;
    fetch_entry_t  head;

    assign bus.ins_valid = (count != '0);
    assign pop  = bus.ins_valid && bus.ins_ready && !redirect;
    assign push = (state == REQ) && bus.imem_ack && !redirect;

    assign push_data.ins  = bus.imem_rdata;
    assign push_data.pc   = req_addr;
    assign push_data.pcp4 = req_addr + PC_STEP;

    assign count_after = count + CW'(push) - CW'(pop);
    assign space_after = (count_after < CW'(DEPTH));

    always_comb begin
        state_d    = state;
        fetch_pc_d = fetch_pc;
        req_addr_d = req_addr;
        case (state)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = word_align(redirect_pc);
                end else if (count < CW'(DEPTH)) begin
                    state_d    = REQ;
                    req_addr_d = fetch_pc;
                end
            end
            REQ: begin
                if (redirect) begin
                    // An ack landing with the redirect closes the request; otherwise drain it.
                    fetch_pc_d = word_align(redirect_pc);
                    state_d    = bus.imem_ack ? IDLE : DROP;
                end else if (bus.imem_ack) begin
                    fetch_pc_d = fetch_pc + PC_STEP;
                    if (space_after) begin
                        req_addr_d = fetch_pc + PC_STEP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    fetch_pc_d = word_align(redirect_pc);
                end
                if (bus.imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= '0;
        end else begin
            state    <= state_d;
            fetch_pc <= fetch_pc_d;
            req_addr <= req_addr_d;
        end
    end

    assign bus.imem_req  = (state != IDLE);
    assign bus.imem_addr = req_addr;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign bus.ins      = head.ins;
    assign bus.pc_out   = head.pc;
    assign bus.pcp4_out = head.pcp4;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!bus.ins_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - directed self-checking bench for fetch_buffer
`timescale 1ns/1ps
module tb_fetch_buffer;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    fetch_buffer_if bus ();

    fetch_buffer #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int lat         = 1;
    int wait_cnt    = 0;

    // Memory responder: ack after lat idle request cycles, data = addr ^ KEY.
    always @(negedge clk) begin
        if (bus.imem_ack) wait_cnt = 0;
        if (bus.imem_req) begin
            if (wait_cnt >= lat) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = bus.imem_addr ^ KEY;
            end else begin
                bus.imem_ack   = 1'b0;
                wait_cnt       = wait_cnt + 1;
            end
        end else begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = 32'h0;
            wait_cnt       = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int n = 0;
        while (!bus.ins_valid && n < max_cycles) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 32'(bus.ins_valid), 32'd1);
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc);
        check({tag, "_ins"},  bus.ins,      pc ^ KEY);
        check({tag, "_pc"},   bus.pc_out,   pc);
        check({tag, "_pcp4"}, bus.pcp4_out, pc + 32'd4);
    endtask

    task automatic wait_req_no_ack(input string tag, input int max_cycles);
        int n = 0;
        while (!(bus.imem_req && !bus.imem_ack) && n < max_cycles) begin
            step();
            n++;
        end
        check({tag, "_req_pending"}, 32'(bus.imem_req && !bus.imem_ack), 32'd1);
    endtask

    initial begin
        logic [31:0] old_addr;
        int          n;

        rst_n         = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = 32'h0;
        bus.ins_ready = 1'b0;
        lat           = 1;
        repeat (3) step();

        check("rst_req",   32'(bus.imem_req),  32'd0);
        check("rst_addr",  bus.imem_addr,      32'd0);
        check("rst_valid", 32'(bus.ins_valid), 32'd0);
        check("rst_ins",   bus.ins,            32'd0);
        check("rst_pc",    bus.pc_out,         32'd0);
        check("rst_pcp4",  bus.pcp4_out,       32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_stall", stall_cnt, 32'd0);
`endif

        rst_n = 1'b1;
        step();
        check("first_req",  32'(bus.imem_req), 32'd1);
        check("first_addr", bus.imem_addr,     32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("stall_one", stall_cnt, 32'd1);
`endif

        // Streaming with decode always ready.
        bus.ins_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid($sformatf("stream%0d", k), 10);
            expect_head($sformatf("stream%0d", k), 32'(k * 4));
            step();
        end

        // Decode stalls: FIFO fills to DEPTH and fetch stops.
        bus.ins_ready = 1'b0;
        repeat (10) step();
        check("full_req",   32'(bus.imem_req),  32'd0);
        check("full_valid", 32'(bus.ins_valid), 32'd1);
        check("full_head",  bus.pc_out,         32'd16);
        repeat (3) step();
        check("full_req_hold", 32'(bus.imem_req), 32'd0);
        bus.ins_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid($sformatf("drain%0d", k), 10);
            expect_head($sformatf("drain%0d", k), 32'(16 + k * 4));
            step();
        end

        // Redirect while a slow request is outstanding.
        lat = 3;
        wait_req_no_ack("drop", 20);
        old_addr    = bus.imem_addr;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        check("drop_valid", 32'(bus.ins_valid), 32'd0);
        check("drop_req",   32'(bus.imem_req),  32'd1);
        check("drop_addr",  bus.imem_addr,      old_addr);
        n = 0;
        while (!(bus.imem_req && bus.imem_addr !== old_addr) && n < 20) begin
            step();
            n++;
        end
        check("redir_addr", bus.imem_addr, 32'h0000_0100);
        wait_valid("redir", 20);
        expect_head("redir", 32'h0000_0100);
        step();

        // Redirect coinciding with an ack and a pop.
        lat           = 1;
        bus.ins_ready = 1'b0;
        n = 0;
        while (!(bus.ins_valid && bus.imem_ack) && n < 20) begin
            step();
            n++;
        end
        check("coinc_setup", 32'(bus.ins_valid && bus.imem_ack), 32'd1);
        bus.ins_ready = 1'b1;
        redirect      = 1'b1;
        redirect_pc   = 32'h0000_0200;
        step();
        redirect = 1'b0;
        check("coinc_valid", 32'(bus.ins_valid), 32'd0);
        check("coinc_req",   32'(bus.imem_req),  32'd0);
        wait_valid("coinc0", 20);
        expect_head("coinc0", 32'h0000_0200);
        step();
        wait_valid("coinc1", 20);
        expect_head("coinc1", 32'h0000_0204);
        step();

        // Wrap at the top of the address space, zero-wait memory.
        lat         = 0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        wait_valid("wrap0", 20);
        expect_head("wrap0", 32'hFFFF_FFF8);
        step();
        check("wrap1_cont", 32'(bus.ins_valid), 32'd1);
        expect_head("wrap1", 32'hFFFF_FFFC);
        check("wrap1_pcp4_zero", bus.pcp4_out, 32'h0000_0000);
        step();
        check("wrap2_cont", 32'(bus.ins_valid), 32'd1);
        expect_head("wrap2", 32'h0000_0000);
        step();

        // Asynchronous reset in the middle of a request.
        lat = 3;
        wait_req_no_ack("arst", 20);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req",   32'(bus.imem_req),  32'd0);
        check("arst_valid", 32'(bus.ins_valid), 32'd0);
        step();
        rst_n = 1'b1;
`ifdef FETCH_PERF_CNT_EN
        check("arst_stall", stall_cnt, 32'd0);
`endif
        n = 0;
        while (!bus.imem_req && n < 10) begin
            step();
            n++;
        end
        check("arst_restart_req",  32'(bus.imem_req), 32'd1);
        check("arst_restart_addr", bus.imem_addr,     32'd0);
        wait_valid("arst", 20);
        expect_head("arst", 32'h0000_0000);
`ifdef FETCH_PERF_CNT_EN
        check("arst_stall_count", stall_cnt, 32'd5);
`endif
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
